// File: rtl/ras_ctrl.sv
// Return-address stack controller with external storage, checkpoint/flush recovery and power-up clear.
// Pop response is one cycle after the accepted pop_req; pushes and pops are ignored while stall is high or ready is low.
module ras_ctrl #(
   parameter int DEPTH = 32,
   parameter int IDX_W = 5
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             push_req,
   input  logic [31:0]      push_addr,
   input  logic             pop_req,
   input  logic             stall,
   input  logic             ckpt_save,
   input  logic             flush,
   input  logic [31:0]      rd_data,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_idx,
   output logic [31:0]      wr_data,
   output logic [IDX_W-1:0] rd_idx,
   output logic             ready,
   output logic             pop_valid,
   output logic             pop_hit,
   output logic [31:0]      pop_addr,
   output logic [IDX_W:0]   count,
   output logic             full,
   output logic             empty
);

   typedef enum logic [1:0] {CLEAR, RUN, RECOVER} state_t;

   localparam logic [IDX_W:0]   DEPTH_C  = (IDX_W+1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] clr_idx, clr_idx_nxt;
   logic [IDX_W-1:0] top, top_nxt;
   logic [IDX_W:0]   cnt, cnt_nxt;
   logic [IDX_W-1:0] ckpt_top, ckpt_top_nxt;
   logic [IDX_W:0]   ckpt_cnt, ckpt_cnt_nxt;
   logic             pv_nxt, ph_nxt;
   logic [31:0]      pa_nxt;

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= CLEAR;
         clr_idx   <= '0;
         top       <= '0;
         cnt       <= '0;
         ckpt_top  <= '0;
         ckpt_cnt  <= '0;
         pop_valid <= 1'b0;
         pop_hit   <= 1'b0;
         pop_addr  <= '0;
      end else begin
         state     <= state_nxt;
         clr_idx   <= clr_idx_nxt;
         top       <= top_nxt;
         cnt       <= cnt_nxt;
         ckpt_top  <= ckpt_top_nxt;
         ckpt_cnt  <= ckpt_cnt_nxt;
         pop_valid <= pv_nxt;
         pop_hit   <= ph_nxt;
         pop_addr  <= pa_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      clr_idx_nxt  = clr_idx;
      top_nxt      = top;
      cnt_nxt      = cnt;
      ckpt_top_nxt = ckpt_top;
      ckpt_cnt_nxt = ckpt_cnt;
      pv_nxt       = 1'b0;
      ph_nxt       = 1'b0;
      pa_nxt       = '0;
      wr_en        = 1'b0;
      wr_idx       = top;
      wr_data      = push_addr;
      case (state)
         CLEAR: begin
            wr_en       = 1'b1;
            wr_idx      = clr_idx;
            wr_data     = '0;
            clr_idx_nxt = clr_idx + 1'b1;
            if (clr_idx == LAST_IDX)
               state_nxt = RUN;
         end
         RUN: begin
            if (flush) begin
               top_nxt   = ckpt_top;
               cnt_nxt   = ckpt_cnt;
               state_nxt = RECOVER;
            end else begin
               if (!stall) begin
                  if (push_req && pop_req) begin
                     // push-then-pop nets out to no change; forward the pushed address
                     pv_nxt = 1'b1;
                     ph_nxt = 1'b1;
                     pa_nxt = push_addr;
                  end else if (push_req) begin
                     wr_en   = 1'b1;
                     top_nxt = top + 1'b1;
                     if (cnt != DEPTH_C)
                        cnt_nxt = cnt + 1'b1;
                  end else if (pop_req) begin
                     pv_nxt = 1'b1;
                     if (cnt != '0) begin
                        ph_nxt  = 1'b1;
                        pa_nxt  = rd_data;
                        top_nxt = top - 1'b1;
                        cnt_nxt = cnt - 1'b1;
                     end
                  end
               end
               if (ckpt_save) begin
                  ckpt_top_nxt = top_nxt;
                  ckpt_cnt_nxt = cnt_nxt;
               end
            end
         end
         RECOVER: state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   assign rd_idx = top - 1'b1;
   assign ready  = (state == RUN);
   assign count  = cnt;
   assign full   = (cnt == DEPTH_C);
   assign empty  = (cnt == '0);

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed and random checks of ras_ctrl against an abstract stack model with a behavioural storage array.
module tb_ras_ctrl;
   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        push_req = 1'b0, pop_req = 1'b0, stall = 1'b0, ckpt_save = 1'b0, flush = 1'b0;
   logic [31:0] push_addr = '0;
   logic [31:0] rd_data;
   logic        wr_en, ready, pop_valid, pop_hit, full, empty;
   logic [4:0]  wr_idx, rd_idx;
   logic [31:0] wr_data, pop_addr;
   logic [5:0]  count;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [32];
   always_ff @(posedge CLK) if (wr_en) mem[wr_idx] <= wr_data;
   assign rd_data = mem[rd_idx];

   ras_ctrl #(.DEPTH(32), .IDX_W(5)) dut (
      .CLK(CLK), .RESET(RESET), .push_req(push_req), .push_addr(push_addr),
      .pop_req(pop_req), .stall(stall), .ckpt_save(ckpt_save), .flush(flush),
      .rd_data(rd_data), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
      .rd_idx(rd_idx), .ready(ready), .pop_valid(pop_valid), .pop_hit(pop_hit),
      .pop_addr(pop_addr), .count(count), .full(full), .empty(empty));

   always #5 CLK = ~CLK;

   // Reference: phase 0=clearing, 1=running, 2=recovering; stack is top/count over a 32-entry ring
   int          m_phase, m_clr, m_top, m_cnt, m_ck_top, m_ck_cnt;
   logic [31:0] m_mem [32];
   bit          m_pv, m_hit;
   logic [31:0] m_pa;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_phase = 0; m_clr = 0; m_top = 0; m_cnt = 0; m_ck_top = 0; m_ck_cnt = 0;
      m_pv = 0; m_hit = 0; m_pa = 0;
   endtask

   task automatic chk_reset_outputs();
      chk("rst_ready", {31'b0, ready}, 0);
      chk("rst_pop_valid", {31'b0, pop_valid}, 0);
      chk("rst_pop_hit", {31'b0, pop_hit}, 0);
      chk("rst_pop_addr", pop_addr, 0);
      chk("rst_count", {26'b0, count}, 0);
      chk("rst_empty", {31'b0, empty}, 1);
      chk("rst_full", {31'b0, full}, 0);
      chk("rst_wr_idx", {27'b0, wr_idx}, 0);
   endtask

   task automatic release_reset();
      @(posedge CLK);
      #2 RESET = 1'b1;
   endtask

   task automatic step(input bit pu, input logic [31:0] pa, input bit po,
                       input bit st, input bit ck, input bit fl);
      bit          e_we;
      logic [31:0] e_wi, e_wd;
      @(negedge CLK);
      push_req = pu; push_addr = pa; pop_req = po; stall = st; ckpt_save = ck; flush = fl;
      #1;
      e_we = 0; e_wi = 0; e_wd = 0;
      if (m_phase == 0) begin
         e_we = 1; e_wi = m_clr; e_wd = 0;
      end else if (m_phase == 1 && !fl && !st && pu && !po) begin
         e_we = 1; e_wi = m_top; e_wd = pa;
      end
      chk("wr_en", {31'b0, wr_en}, {31'b0, e_we});
      if (e_we) begin
         chk("wr_idx", {27'b0, wr_idx}, e_wi);
         chk("wr_data", wr_data, e_wd);
      end
      chk("ready", {31'b0, ready}, (m_phase == 1) ? 1 : 0);
      chk("rd_idx", {27'b0, rd_idx}, (m_top + 31) % 32);

      m_pv = 0; m_hit = 0; m_pa = 0;
      case (m_phase)
         0: begin
            m_mem[m_clr] = 0;
            m_clr++;
            if (m_clr == 32) begin m_phase = 1; m_clr = 0; end
         end
         1: begin
            if (fl) begin
               m_top = m_ck_top; m_cnt = m_ck_cnt; m_phase = 2;
            end else begin
               if (!st) begin
                  if (pu && po) begin
                     m_pv = 1; m_hit = 1; m_pa = pa;
                  end else if (pu) begin
                     m_mem[m_top] = pa;
                     m_top = (m_top + 1) % 32;
                     if (m_cnt < 32) m_cnt++;
                  end else if (po) begin
                     m_pv = 1;
                     if (m_cnt > 0) begin
                        m_top = (m_top + 31) % 32;
                        m_hit = 1; m_pa = m_mem[m_top];
                        m_cnt--;
                     end
                  end
               end
               if (ck) begin m_ck_top = m_top; m_ck_cnt = m_cnt; end
            end
         end
         default: m_phase = 1;
      endcase

      @(posedge CLK);
      #1;
      push_req = 0; pop_req = 0; stall = 0; ckpt_save = 0; flush = 0;
      chk("count", {26'b0, count}, m_cnt);
      chk("full", {31'b0, full}, (m_cnt == 32) ? 1 : 0);
      chk("empty", {31'b0, empty}, (m_cnt == 0) ? 1 : 0);
      chk("pop_valid", {31'b0, pop_valid}, {31'b0, m_pv});
      if (m_pv) begin
         chk("pop_hit", {31'b0, pop_hit}, {31'b0, m_hit});
         chk("pop_addr", pop_addr, m_pa);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // power-up reset and full clear sequence
      model_reset();
      #12;
      chk_reset_outputs();
      release_reset();
      idle(32);
      idle(1);
      chk("ready_after_clear", {31'b0, ready}, 1);

      // LIFO ordering
      step(1, 32'h100, 0, 0, 0, 0);
      step(1, 32'h200, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("lifo_pop1", pop_addr, 32'h200);
      step(0, 0, 1, 0, 0, 0);
      chk("lifo_pop2", pop_addr, 32'h100);
      chk("lifo_hit2", {31'b0, pop_hit}, 1);
      chk("lifo_empty", {31'b0, empty}, 1);

      // overflow overwrites oldest, then drain and underflow
      for (int i = 0; i < 33; i++) step(1, 32'h1000 + 32'(4 * i), 0, 0, 0, 0);
      chk("ovf_count", {26'b0, count}, 32);
      chk("ovf_full", {31'b0, full}, 1);
      for (int k = 0; k < 32; k++) begin
         step(0, 0, 1, 0, 0, 0);
         chk("ovf_pop", pop_addr, 32'h1000 + 32'(4 * (32 - k)));
      end
      step(0, 0, 1, 0, 0, 0);
      chk("udf_hit", {31'b0, pop_hit}, 0);
      chk("udf_addr", pop_addr, 0);

      // simultaneous push and pop bypass
      step(1, 32'h40, 0, 0, 0, 0);
      step(1, 32'h80, 1, 0, 0, 0);
      chk("byp_addr", pop_addr, 32'h80);
      chk("byp_hit", {31'b0, pop_hit}, 1);
      chk("byp_count", {26'b0, count}, 1);

      // checkpoint and flush recovery
      step(0, 0, 0, 0, 1, 0);
      step(1, 32'h80, 0, 0, 0, 0);
      step(1, 32'h90, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("rec_ready", {31'b0, ready}, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("rec_pop_valid", {31'b0, pop_valid}, 0);
      idle(1);
      chk("rec_count", {26'b0, count}, 1);
      step(0, 0, 1, 0, 0, 0);
      chk("rec_pop", pop_addr, 32'h40);

      // random traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 99) < 50, $urandom, $urandom_range(0, 99) < 40,
              $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 5);

      // reset in the middle of the clear sequence
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      model_reset();
      chk_reset_outputs();
      release_reset();
      idle(10);
      @(negedge CLK);
      RESET = 1'b0;
      #1;
      model_reset();
      chk_reset_outputs();
      chk("midclr_wr_en", {31'b0, wr_en}, 1);
      release_reset();
      idle(33);
      chk("midclr_ready", {31'b0, ready}, 1);
      step(1, 32'h55, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("post_reset_pop", pop_addr, 32'h55);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/ras_ctrl.md
RAS_CTRL -- requirements
Module: ras_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 32, the number of stack entries (power of two).
REQ-002 SHALL have parameter IDX_W, default 5, the entry index width (log2 DEPTH).
REQ-003 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port RESET  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port push_req  in  1  JAL/JALR resolved in ID.
REQ-006 SHALL have port push_addr  in  32  return address to push (InstrPC_ID + 8).
REQ-007 SHALL have port pop_req  in  1  JR $ra decoded in IF.
REQ-008 SHALL have port stall  in  1  pipeline stall; while 1, push_req and pop_req are ignored.
REQ-009 SHALL have port ckpt_save  in  1  snapshot the stack state when a branch is predicted.
REQ-010 SHALL have port flush  in  1  misprediction; restore the snapshot.
REQ-011 SHALL have port rd_data  in  32  storage read data, combinational from rd_idx.
REQ-012 SHALL have port wr_en  out  1  storage write strobe.
REQ-013 SHALL have port wr_idx  out  IDX_W  storage write index.
REQ-014 SHALL have port wr_data  out  32  storage write data.
REQ-015 SHALL have port rd_idx  out  IDX_W  storage read index, equal to top-1 mod DEPTH.
REQ-016 SHALL have port ready  out  1  controller is in RUN.
REQ-017 SHALL have ports pop_valid, pop_hit, pop_addr  out  1/1/32  registered pop response.
REQ-018 SHALL have ports count, full, empty  out  IDX_W+1/1/1  occupancy status.

Function
REQ-019 SHALL implement the states CLEAR, RUN and RECOVER.
REQ-020 In CLEAR, SHALL write 0 to indices 0..DEPTH-1, one per cycle, then enter RUN; push and pop are ignored and ready=0.
REQ-021 Stack SHALL be circular: a top index (IDX_W bits, wrapping) plus a count (0..DEPTH).
REQ-022 On a push only: SHALL drive wr_en=1, wr_idx=top and wr_data=push_addr; top increments; count increments, saturating at DEPTH.
REQ-023 On a push when full: SHALL overwrite the oldest entry; count stays at DEPTH.
REQ-024 On a pop only with count>0: SHALL set pop_hit=1 and pop_addr=rd_data in the next cycle; top and count each decrement.
REQ-025 On a pop only with count=0: SHALL set pop_hit=0 and pop_addr=0 in the next cycle; state is unchanged.
REQ-026 pop_valid SHALL equal 1 in the cycle after any accepted pop_req.
REQ-027 On a simultaneous push and pop: push is logically first; SHALL return pop_hit=1 and pop_addr=push_addr (bypass); no write; top and count unchanged.
REQ-028 ckpt_save SHALL capture {top, count} into a single checkpoint register; a push or pop in the same cycle SHALL be reflected in the captured value (post-update).
REQ-029 flush in RUN SHALL have priority over push, pop and ckpt_save, which are all dropped; on the next edge SHALL load top and count from the checkpoint and enter RECOVER.
REQ-030 RECOVER SHALL last one cycle with ready=0, requests ignored and pop_valid=0, then return to RUN.
REQ-031 flush in CLEAR or RECOVER SHALL be ignored.
REQ-032 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both combinational from registers.

Reset
REQ-033 While RESET=0: state=CLEAR with clear index 0; top=0, count=0; checkpoint={0,0}; pop_valid, pop_hit and pop_addr = 0; ready=0.
REQ-034 Release of RESET SHALL start the DEPTH-cycle clear sequence.
REQ-035 Assertion of RESET at any point, including mid-CLEAR or mid-RECOVER, SHALL immediately return to the reset values.

Verification
REQ-036 Reset, then idle: wr_en is high for exactly 32 cycles at wr_idx 0..31 with wr_data=0; ready rises in cycle 33.
REQ-037 Push 0x100 then 0x200, then pop twice: pops return 0x200, then 0x100, each with pop_hit=1; empty=1 afterwards.
REQ-038 Push 33 addresses A0..A32: count=32, full=1; 32 pops return A32..A1; a 33rd pop gives pop_hit=0 and pop_addr=0.
REQ-039 With stack [0x40], push 0x80 and pop in the same cycle: pop_addr=0x80 and pop_hit=1; count stays 1; wr_en=0.
REQ-040 With stack [0x40], ckpt_save, push 0x80, push 0x90, then flush: after RECOVER, count=1 and the next pop returns 0x40.
REQ-041 Assert RESET at clear index 10: all outputs return to reset values; after release, the clear sequence restarts at index 0.
